// File: rtl/frame_lock_pkg.sv
// Shared types and default constants for the frame lock monitor.
package frame_lock_pkg;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    CONFIRM  = 2'd1,
    LOCKED   = 2'd2,
    FLYWHEEL = 2'd3
  } lock_state_e;

  localparam int unsigned LOCK_CNT_DEF    = 3;
  localparam int unsigned UNLOCK_CNT_DEF  = 2;
  localparam int unsigned TIMEOUT_CYC_DEF = 12;
  localparam int unsigned CNT_W_DEF       = 16;

  // Run counters only ever need to reach 15.
  localparam int unsigned RUN_W = 4;
  // Silence counter only ever needs to reach 255.
  localparam int unsigned SIL_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear first, otherwise step unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/frame_lock_monitor.sv
// Framing-lock monitor fed by the frame detector's match / not_match pulses.
// Optional silence watchdog: define FRAME_LOCK_TIMEOUT_EN to enable it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HUNT     | no alignment, waiting for a first match
// CONFIRM  | counting consecutive matches towards LOCK_CNT
// LOCKED   | aligned, matches arriving
// FLYWHEEL | aligned but missing; counting misses towards UNLOCK_CNT
module frame_lock_monitor
  import frame_lock_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = LOCK_CNT_DEF,
  parameter int unsigned UNLOCK_CNT  = UNLOCK_CNT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             match,
  input  logic             not_match,
  input  logic             clr,
  output logic             locked,
  output logic             lock_acq,
  output logic             lock_loss,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] match_total,
  output logic [CNT_W-1:0] miss_total,
  output logic             err
);

  lock_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] miss_run_q, miss_run_d;
  logic             locked_q, locked_d;
  logic             acq_q, acq_d;
  logic             loss_q, loss_d;
  logic             err_q, err_d;

  logic             ev_valid;
  logic [RUN_W:0]   run_inc;
  logic [RUN_W:0]   miss_run_inc;
  logic             timeout;

  assign ev_valid     = match ^ not_match;
  assign run_inc      = {1'b0, run_q} + (RUN_W+1)'(1);
  assign miss_run_inc = {1'b0, miss_run_q} + (RUN_W+1)'(1);

`ifdef FRAME_LOCK_TIMEOUT_EN
  logic [SIL_W-1:0] sil_q, sil_d;
  logic [SIL_W:0]   sil_inc;

  assign sil_inc = {1'b0, sil_q} + (SIL_W+1)'(1);
  // An event in the same cycle always beats the watchdog.
  assign timeout = (state_q != HUNT) && !ev_valid &&
                   (sil_inc == (SIL_W+1)'(TIMEOUT_CYC));

  // Silence counter: idle in HUNT, restarted by any valid event or expiry.
  always_comb begin
    sil_d = sil_inc[SIL_W-1:0];
    if ((state_q == HUNT) || ev_valid || timeout) begin
      sil_d = '0;
    end
  end

  // Silence counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sil_q <= '0;
    end else begin
      sil_q <= sil_d;
    end
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // Next state, run counters and next values of the registered pulses.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    miss_run_d = miss_run_q;
    acq_d      = 1'b0;
    loss_d     = 1'b0;
    err_d      = match & not_match;

    if (ev_valid) begin
      unique case (state_q)
        HUNT: begin
          if (match) begin
            if (LOCK_CNT == 1) begin
              state_d = LOCKED;
              acq_d   = 1'b1;
            end else begin
              state_d = CONFIRM;
              run_d   = RUN_W'(1);
            end
          end
        end
        CONFIRM: begin
          if (match) begin
            if (run_inc == (RUN_W+1)'(LOCK_CNT)) begin
              state_d = LOCKED;
              acq_d   = 1'b1;
              run_d   = '0;
            end else begin
              run_d = run_inc[RUN_W-1:0];
            end
          end else begin
            state_d = HUNT;
            run_d   = '0;
          end
        end
        LOCKED: begin
          if (not_match) begin
            if (UNLOCK_CNT == 1) begin
              state_d = HUNT;
              loss_d  = 1'b1;
            end else begin
              state_d    = FLYWHEEL;
              miss_run_d = RUN_W'(1);
            end
          end
        end
        FLYWHEEL: begin
          if (match) begin
            state_d    = LOCKED;
            miss_run_d = '0;
          end else if (miss_run_inc == (RUN_W+1)'(UNLOCK_CNT)) begin
            state_d    = HUNT;
            loss_d     = 1'b1;
            miss_run_d = '0;
          end else begin
            miss_run_d = miss_run_inc[RUN_W-1:0];
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (timeout) begin
      state_d    = HUNT;
      run_d      = '0;
      miss_run_d = '0;
      loss_d     = (state_q == LOCKED) || (state_q == FLYWHEEL);
    end

    locked_d = (state_d == LOCKED) || (state_d == FLYWHEEL);
  end

  // State, run counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      run_q      <= '0;
      miss_run_q <= '0;
      locked_q   <= 1'b0;
      acq_q      <= 1'b0;
      loss_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      miss_run_q <= miss_run_d;
      locked_q   <= locked_d;
      acq_q      <= acq_d;
      loss_q     <= loss_d;
      err_q      <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_total (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ev_valid & match),
    .clr   (clr),
    .cnt   (match_total)
  );

  sat_counter #(.W(CNT_W)) u_miss_total (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ev_valid & not_match),
    .clr   (clr),
    .cnt   (miss_total)
  );

  assign state     = state_q;
  assign locked    = locked_q;
  assign lock_acq  = acq_q;
  assign lock_loss = loss_q;
  assign err       = err_q;

endmodule

// File: tb/tb_frame_lock_monitor.sv
// Scoreboard bench for frame_lock_monitor (LOCK_CNT=3, UNLOCK_CNT=2, CNT_W=4).
module tb_frame_lock_monitor;

  localparam int LOCK_CNT    = 3;
  localparam int UNLOCK_CNT  = 2;
  localparam int CNT_W       = 4;
  localparam int TIMEOUT_CYC = 12;
  localparam int SAT_MAX     = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             match;
  logic             not_match;
  logic             clr;
  logic             locked;
  logic             lock_acq;
  logic             lock_loss;
  logic [1:0]       state;
  logic [CNT_W-1:0] match_total;
  logic [CNT_W-1:0] miss_total;
  logic             err;

  frame_lock_monitor #(
    .LOCK_CNT    (LOCK_CNT),
    .UNLOCK_CNT  (UNLOCK_CNT),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .match       (match),
    .not_match   (not_match),
    .clr         (clr),
    .locked      (locked),
    .lock_acq    (lock_acq),
    .lock_loss   (lock_loss),
    .state       (state),
    .match_total (match_total),
    .miss_total  (miss_total),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int lk;
    int acq;
    int loss;
    int er;
    int mt;
    int ms;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_st, m_run, m_mrun, m_sil, m_mt, m_ms;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_run = 0; m_mrun = 0; m_sil = 0; m_mt = 0; m_ms = 0;
  endtask

  task automatic model_step(input bit m, input bit nm, input bit c, output exp_t e);
    bit v;
    v = m ^ nm;
    e.acq = 0;
    e.loss = 0;
    e.er = (m && nm) ? 1 : 0;
    if (v) begin
      m_sil = 0;
      if (m_st == 0) begin
        if (m) begin
          if (LOCK_CNT == 1) begin m_st = 2; e.acq = 1; end
          else begin m_st = 1; m_run = 1; end
        end
      end else if (m_st == 1) begin
        if (m) begin
          m_run++;
          if (m_run == LOCK_CNT) begin m_st = 2; e.acq = 1; m_run = 0; end
        end else begin
          m_st = 0; m_run = 0;
        end
      end else if (m_st == 2) begin
        if (nm) begin
          if (UNLOCK_CNT == 1) begin m_st = 0; e.loss = 1; end
          else begin m_st = 3; m_mrun = 1; end
        end
      end else begin
        if (m) begin
          m_st = 2; m_mrun = 0;
        end else begin
          m_mrun++;
          if (m_mrun == UNLOCK_CNT) begin m_st = 0; e.loss = 1; m_mrun = 0; end
        end
      end
    end else begin
`ifdef FRAME_LOCK_TIMEOUT_EN
      if (m_st != 0) begin
        m_sil++;
        if (m_sil == TIMEOUT_CYC) begin
          e.loss = (m_st >= 2) ? 1 : 0;
          m_st = 0; m_run = 0; m_mrun = 0;
        end
      end
`endif
    end
    if (m_st == 0) m_sil = 0;
    if (c) begin
      m_mt = 0;
      m_ms = 0;
    end else begin
      if (v && m && m_mt < SAT_MAX) m_mt++;
      if (v && nm && m_ms < SAT_MAX) m_ms++;
    end
    e.st = m_st;
    e.lk = (m_st >= 2) ? 1 : 0;
    e.mt = m_mt;
    e.ms = m_ms;
  endtask

  // Drive one cycle of stimulus, queue the prediction, compare after the edge.
  task automatic cyc(input bit m, input bit nm, input bit c);
    exp_t e;
    @(negedge clk);
    match = m;
    not_match = nm;
    clr = c;
    model_step(m, nm, c, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_val("state", int'(state), e.st);
      check_val("locked", int'(locked), e.lk);
      check_val("lock_acq", int'(lock_acq), e.acq);
      check_val("lock_loss", int'(lock_loss), e.loss);
      check_val("err", int'(err), e.er);
      check_val("match_total", int'(match_total), e.mt);
      check_val("miss_total", int'(miss_total), e.ms);
    end
  endtask

  // One detector frame: a pulse followed by five quiet cycles.
  task automatic frame(input bit m, input bit nm);
    cyc(m, nm, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    match = 1'b0;
    not_match = 1'b0;
    clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_state", int'(state), 0);
    check_val("rst_locked", int'(locked), 0);
    check_val("rst_acq", int'(lock_acq), 0);
    check_val("rst_loss", int'(lock_loss), 0);
    check_val("rst_err", int'(err), 0);
    check_val("rst_mt", int'(match_total), 0);
    check_val("rst_ms", int'(miss_total), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Acquire lock with three matches.
    for (int i = 0; i < 3; i++) frame(1'b1, 1'b0);
    check_val("t1_state", int'(state), 2);
    check_val("t1_mt", int'(match_total), 3);

    // Miss, recover, then two misses drop lock.
    frame(1'b0, 1'b1);
    check_val("t2_fly", int'(state), 3);
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b1);
    check_val("t2_state", int'(state), 0);
    check_val("t2_ms", int'(miss_total), 3);

    // Abort CONFIRM, then need three fresh matches.
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    check_val("t3_confirm", int'(state), 1);
    frame(1'b0, 1'b1);
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    check_val("t3_not_yet", int'(state), 1);
    frame(1'b1, 1'b0);
    check_val("t3_state", int'(state), 2);

    // Protocol violation while locked.
    cyc(1'b1, 1'b1, 1'b0);
    check_val("t4_err", int'(err), 1);
    cyc(1'b0, 1'b0, 1'b0);

    // Saturation and clr priority.
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0);
    check_val("t5_sat", int'(match_total), 15);
    cyc(1'b1, 1'b0, 1'b1);
    check_val("t5_clr", int'(match_total), 0);

    // Twelve quiet cycles in LOCKED.
    for (int i = 0; i < TIMEOUT_CYC; i++) cyc(1'b0, 1'b0, 1'b0);
`ifdef FRAME_LOCK_TIMEOUT_EN
    check_val("t6_timeout_state", int'(state), 0);
`else
    check_val("t6_hold_locked", int'(locked), 1);
`endif
    cyc(1'b0, 1'b0, 1'b0);

    // Relock if needed, then asynchronous reset mid-lock.
    for (int i = 0; i < 3; i++) frame(1'b1, 1'b0);
    check_val("t7_locked", int'(locked), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("t7_rst_state", int'(state), 0);
    check_val("t7_rst_locked", int'(locked), 0);
    check_val("t7_rst_loss", int'(lock_loss), 0);
    check_val("t7_rst_mt", int'(match_total), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
